// File: rtl/accel_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accel_sched_pkg
// Description : Shared constants and types for the accelerator job scheduler:
//               register offsets, STATUS/IRQ/CTRL bit indices, AXI response
//               codes and the sequencing state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package accel_sched_pkg;

    // Register word index, decoded from address bits [4:2]
    localparam logic [2:0] REG_JOB      = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_DONE_CNT = 3'd2;
    localparam logic [2:0] REG_CTRL     = 3'd3;
    localparam logic [2:0] REG_IRQ      = 3'd4;
    localparam logic [2:0] REG_IRQ_MASK = 3'd5;

    // STATUS bit positions; the FIFO count occupies [15:8]
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_ERR_BIT   = 3;

    // CTRL bit positions
    localparam int CTRL_CLEAR_BIT = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    // IRQ status/mask bit positions
    localparam int IRQ_DONE_BIT = 0;
    localparam int IRQ_ERR_BIT  = 1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Job sequencing states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } sched_state_e;

    // FIFO occupancy squeezed into the 8-bit STATUS field (saturates at 255)
    function automatic logic [7:0] sat_count8(input logic [31:0] cnt);
        return (cnt > 32'd255) ? 8'hFF : cnt[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/accel_job_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sched_fifo
// Description : Synchronous DEPTH x DW job FIFO with push, pop, flush and an
//               occupancy count. Output data is the head entry (show-ahead).
//               Push to a full FIFO and pop from an empty FIFO are ignored;
//               flush overrides push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          w_do_push;
    logic          w_do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; flush discards everything queued
    always_comb begin
        w_do_push = push & ~full;
        w_do_pop  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    // Pointer/count registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge aclk) begin
        if (w_do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/accel_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : accel_job_scheduler
// Description : AXI-Lite slave that queues 32-bit job descriptors and
//               sequences the accelerator through a start pulse / Finish
//               rising-edge handshake, one job at a time, with a watchdog,
//               completion counter, sticky error flag and flush/clear control.
//               Optional macro SCHED_IRQ_EN adds the irq output and the
//               IRQ (0x10, W1C) / IRQ_MASK (0x14) registers.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_job_scheduler
    import accel_sched_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        start,
    output logic [31:0] job_arg,
    input  logic        Finish,
    output logic        busy
`ifdef SCHED_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    sched_state_e     state_q, state_d;
    logic             awready_q, awready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             start_q, start_d;
    logic [31:0]      job_arg_q, job_arg_d;
    logic             finish_q;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             done_ok_q, done_ok_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic                   w_wr_en, w_rd_en, w_push, w_pop;
    logic                   w_clear, w_flush, w_finish_rise;
    logic                   w_tmo_evt, w_done_evt;
    logic [2:0]             w_wr_sel, w_rd_sel;
    logic [31:0]            w_rd_data, w_status, w_fifo_dout;
    logic                   w_full, w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_unused;

    assign awready = awready_q;
    assign wready  = awready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = RESP_OKAY;
    assign start   = start_q;
    assign job_arg = job_arg_q;
    assign busy    = (state_q == S_LAUNCH) || (state_q == S_WAIT);

    assign w_wr_sel      = awaddr[4:2];
    assign w_rd_sel      = araddr[4:2];
    assign w_wr_en       = awready_q & awvalid & wvalid;
    assign w_rd_en       = arready_q & arvalid;
    assign w_push        = w_wr_en && (w_wr_sel == REG_JOB) && !w_full;
    assign w_clear       = w_wr_en && (w_wr_sel == REG_CTRL) && wdata[CTRL_CLEAR_BIT];
    assign w_flush       = w_wr_en && (w_wr_sel == REG_CTRL) && wdata[CTRL_FLUSH_BIT];
    assign w_finish_rise = Finish & ~finish_q;

    sched_fifo #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (w_push),
        .din     (wdata),
        .pop     (w_pop),
        .flush   (w_flush),
        .dout    (w_fifo_dout),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // AXI-Lite write/read channel handshakes; ready is a one-cycle pulse
    always_comb begin
        awready_d = awvalid & wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (w_wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = ((w_wr_sel == REG_JOB) && w_full) ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        arready_d = arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (w_rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = w_rd_data;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Register read multiplexer
    always_comb begin
        w_status                   = '0;
        w_status[STATUS_BUSY_BIT]  = busy;
        w_status[STATUS_FULL_BIT]  = w_full;
        w_status[STATUS_EMPTY_BIT] = w_empty;
        w_status[STATUS_ERR_BIT]   = err_q;
        w_status[15:8]             = sat_count8(32'(w_count));
        w_rd_data                  = '0;
        case (w_rd_sel)
            REG_STATUS:   w_rd_data = w_status;
            REG_DONE_CNT: w_rd_data = 32'(done_cnt_q);
`ifdef SCHED_IRQ_EN
            REG_IRQ:      w_rd_data = {30'd0, irq_q};
            REG_IRQ_MASK: w_rd_data = {30'd0, irq_mask_q};
`endif
            default:      w_rd_data = '0;
        endcase
    end

    // Job sequencing: pop and launch, wait for Finish edge or watchdog
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        job_arg_d  = job_arg_q;
        tmo_d      = '0;
        done_ok_d  = done_ok_q;
        w_pop      = 1'b0;
        w_tmo_evt  = 1'b0;
        w_done_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    job_arg_d = w_fifo_dout;
                    start_d   = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (w_finish_rise) begin
                    done_ok_d = 1'b1;
                    state_d   = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_MAX)) begin
                    done_ok_d = 1'b0;
                    w_tmo_evt = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                w_done_evt = done_ok_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky error and completion counter; a CTRL clear beats any update
    always_comb begin
        err_d      = err_q;
        done_cnt_d = done_cnt_q;
        if (w_clear) begin
            err_d      = 1'b0;
            done_cnt_d = '0;
        end else begin
            if (w_tmo_evt)  err_d      = 1'b1;
            if (w_done_evt) done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    // Main state registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            start_q    <= 1'b0;
            job_arg_q  <= '0;
            finish_q   <= 1'b0;
            tmo_q      <= '0;
            done_ok_q  <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            start_q    <= start_d;
            job_arg_q  <= job_arg_d;
            finish_q   <= Finish;
            tmo_q      <= tmo_d;
            done_ok_q  <= done_ok_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
        end
    end

`ifdef SCHED_IRQ_EN
    logic [1:0] irq_q, irq_d;
    logic [1:0] irq_mask_q, irq_mask_d;

    assign irq = |(irq_q & irq_mask_q);

    // Interrupt status (W1C, set wins over clear) and mask register
    always_comb begin
        irq_d      = irq_q;
        irq_mask_d = irq_mask_q;
        if (w_wr_en && (w_wr_sel == REG_IRQ))      irq_d      = irq_q & ~wdata[1:0];
        if (w_wr_en && (w_wr_sel == REG_IRQ_MASK)) irq_mask_d = wdata[1:0];
        if (w_done_evt) irq_d[IRQ_DONE_BIT] = 1'b1;
        if (w_tmo_evt)  irq_d[IRQ_ERR_BIT]  = 1'b1;
    end

    // Interrupt registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_q      <= '0;
            irq_mask_q <= '0;
        end else begin
            irq_q      <= irq_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign w_unused = ^{wstrb, awaddr[31:5], awaddr[1:0], araddr[31:5], araddr[1:0]};
`else
    assign w_unused = ^{wstrb, awaddr[31:5], awaddr[1:0], araddr[31:5], araddr[1:0],
                        REG_IRQ, REG_IRQ_MASK, IRQ_DONE_BIT, IRQ_ERR_BIT};
`endif

endmodule
`default_nettype wire

// File: tb/tb_accel_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_job_scheduler
// Description : Scoreboard bench for accel_job_scheduler. Stimulus tasks push
//               expected B responses, R data and launch descriptors into
//               queues; a negedge monitor pops and compares on each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_job_scheduler;

    localparam int DEPTH = 8;
    localparam int TMO   = 80;
    localparam int CNT_W = 16;

    localparam logic [31:0] A_JOB    = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_DONE   = 32'h08;
    localparam logic [31:0] A_CTRL   = 32'h0C;
    localparam logic [31:0] A_UNMAP  = 32'h18;

    typedef struct {
        logic [31:0] arg;
        int          cyc;
    } start_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic        arvalid = 1'b0, rready = 1'b1, Finish = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        awready, wready, bvalid, arready, rvalid, start, busy;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, job_arg;
`ifdef SCHED_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [1:0]  exp_b[$];
    logic [31:0] exp_r[$];
    start_t      exp_s[$];

    accel_job_scheduler #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CNT_W)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .start   (start),
        .job_arg (job_arg),
        .Finish  (Finish),
        .busy    (busy)
`ifdef SCHED_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: compare every completed transfer and launch against the queues
    always @(negedge aclk) begin
        if (aresetn) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) fail_now("unexpected_bresp");
                else chk("bresp", {30'd0, bresp}, {30'd0, exp_b.pop_front()});
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) fail_now("unexpected_rdata");
                else begin
                    chk("rdata", rdata, exp_r.pop_front());
                    chk("rresp", {30'd0, rresp}, 32'd0);
                end
            end
            if (start) begin
                if (exp_s.size() == 0) fail_now("unexpected_start");
                else begin
                    start_t e;
                    e = exp_s.pop_front();
                    chk("job_arg", job_arg, e.arg);
                    if (e.cyc >= 0) chk("start_latency", cyc, e.cyc);
                end
            end
        end
    end

    // launch: 0 = no start expected, 1 = start expected, 2 = start 2 cycles after handshake
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] exp, input int launch, input int stall);
        int     n;
        start_t e;
        exp_b.push_back(exp);
        @(posedge aclk); #1;
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = (stall == 0);
        n = 0;
        @(negedge aclk);
        while (!awready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (!awready) begin
            fail_now("aw_handshake_timeout");
            awvalid = 1'b0;
            wvalid  = 1'b0;
            bready  = 1'b1;
            return;
        end
        chk("wready_with_awready", {31'd0, wready}, 32'd1);
        if (launch != 0) begin
            e.arg = data;
            e.cyc = (launch == 2) ? cyc + 2 : -1;
            exp_s.push_back(e);
        end
        @(posedge aclk); #1;
        if (stall != 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge aclk);
                chk("b_stall_bvalid", {31'd0, bvalid}, 32'd1);
                chk("b_stall_bresp", {30'd0, bresp}, {30'd0, exp});
                chk("b_stall_awready", {31'd0, awready}, 32'd0);
            end
            @(posedge aclk); #1;
            bready = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!(bvalid && bready) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (!(bvalid && bready)) fail_now("b_response_timeout");
        @(posedge aclk); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int stall);
        int n;
        exp_r.push_back(exp);
        @(posedge aclk); #1;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (stall == 0);
        n = 0;
        @(negedge aclk);
        while (!arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (!arready) begin
            fail_now("ar_handshake_timeout");
            arvalid = 1'b0;
            rready  = 1'b1;
            return;
        end
        @(posedge aclk); #1;
        if (stall != 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge aclk);
                chk("r_stall_rvalid", {31'd0, rvalid}, 32'd1);
                chk("r_stall_rdata", rdata, exp);
                chk("r_stall_arready", {31'd0, arready}, 32'd0);
            end
            @(posedge aclk); #1;
            rready = 1'b1;
        end
        arvalid = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!(rvalid && rready) && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (!(rvalid && rready)) fail_now("r_response_timeout");
        @(posedge aclk); #1;
    endtask

    // Wait for the running job to reach WAIT, pulse Finish, wait for DONE
    task automatic finish_job();
        int n;
        n = 0;
        @(negedge aclk);
        while (!(busy && !start) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!(busy && !start)) begin
            fail_now("finish_job_no_wait_state");
            return;
        end
        @(posedge aclk); #1;
        Finish = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        Finish = 1'b0;
        n = 0;
        @(negedge aclk);
        while (busy && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (busy) fail_now("finish_job_busy_stuck");
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int guard;

        // Reset values
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_start",   {31'd0, start},   32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_job_arg", job_arg,          32'd0);
        chk("rst_resp",    {28'd0, bresp, rresp}, 32'd0);
        chk("rst_rdata",   rdata,            32'd0);
        axi_read(A_STATUS, 32'h0000_0004, 0);
        axi_read(A_DONE,   32'd0, 0);

        // Single job from idle: start 2 cycles after handshake, busy in LAUNCH
        axi_write(A_JOB, 32'h11, 2'b00, 2, 0);
        @(negedge aclk);
        chk("busy_after_launch", {31'd0, busy}, 32'd1);
        finish_job();
        axi_read(A_DONE, 32'd1, 0);

        // Clear, then three sequential jobs
        axi_write(A_CTRL, 32'h1, 2'b00, 0, 0);
        axi_read(A_DONE, 32'd0, 0);
        axi_write(A_JOB, 32'hA1, 2'b00, 1, 0);
        axi_write(A_JOB, 32'hA2, 2'b00, 1, 0);
        axi_write(A_JOB, 32'hA3, 2'b00, 1, 0);
        for (int j = 0; j < 3; j++) finish_job();
        axi_read(A_DONE,   32'd3, 0);
        axi_read(A_STATUS, 32'h0000_0004, 0);

        // Fill FIFO while busy, overflow write, then flush the queue
        axi_write(A_JOB, 32'hB0, 2'b00, 1, 0);
        for (int j = 0; j < DEPTH; j++) axi_write(A_JOB, 32'hC0 + j, 2'b00, 0, 0);
        axi_write(A_JOB, 32'hC8, 2'b10, 0, 0);
        axi_read(A_STATUS, 32'h0000_0803, 0);
        axi_write(A_CTRL, 32'h2, 2'b00, 0, 0);
        axi_read(A_STATUS, 32'h0000_0005, 0);
        finish_job();
        idle_cycles(10);
        axi_read(A_DONE, 32'd4, 0);

        // Watchdog: Finish held low, busy for LAUNCH + TMO WAIT cycles
        axi_write(A_JOB, 32'h55, 2'b00, 1, 0);
        busy_cnt = 0;
        guard    = 0;
        fork
            begin
                @(negedge aclk);
                while (busy && guard < 400) begin
                    busy_cnt++;
                    guard++;
                    @(negedge aclk);
                end
                chk("timeout_busy_cycles", busy_cnt, TMO + 1);
            end
            axi_write(A_JOB, 32'h66, 2'b00, 1, 0);
        join
        axi_read(A_STATUS, 32'h0000_000D, 0);
        axi_read(A_DONE,   32'd4, 0);
        finish_job();
        axi_read(A_DONE,   32'd5, 0);
        axi_write(A_CTRL, 32'h1, 2'b00, 0, 0);
        axi_read(A_STATUS, 32'h0000_0004, 0);
        axi_read(A_DONE,   32'd0, 0);

        // Backpressure on R and B, unmapped and write-only offsets
        axi_read(A_STATUS, 32'h0000_0004, 5);
        axi_write(A_UNMAP, 32'hDEAD_BEEF, 2'b00, 0, 5);
        axi_read(A_UNMAP, 32'd0, 0);
        axi_read(A_JOB,   32'd0, 0);
        idle_cycles(5);

        chk("pending_b", exp_b.size(), 32'd0);
        chk("pending_r", exp_r.size(), 32'd0);
        chk("pending_start", exp_s.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
